// File: rtl/inv_f_round_pkg.sv
// -----------------------------------------------------------------------------
// inv_f_round_pkg
// Shared AES definitions for the round datapath: block geometry constants,
// the round-control FSM state type and the GF(2^8) helpers. The encryptor
// mixcolumns and this decryptor's inv_mixcolumns use the same helpers.
// -----------------------------------------------------------------------------
package inv_f_round_pkg;

  localparam int          AES_NB    = 4;      // columns per state
  localparam int          AES_BYTES = 16;     // bytes per state
  localparam logic [7:0]  GF_POLY   = 8'h1B;  // x^8 + x^4 + x^3 + x + 1, low byte

  typedef enum logic [1:0] {
    IDLE,
    MIX,
    SUB,
    OUT
  } fsm_state_t;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add. With a constant b, synthesis
  // folds it down to a few xtime stages and XORs.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_f_round_inv_mixcolumns.sv
// -----------------------------------------------------------------------------
// inv_mixcolumns
// Combinational AES InvMixColumns over a full 128-bit state.
//   state_in  : state, byte0 = [127:120], column-major (bytes 4c..4c+3 = col c)
//   bypass    : 1 = pass state_in through unchanged (final inverse round)
//   state_out : transformed state, same layout
// -----------------------------------------------------------------------------
module inv_mixcolumns
  import inv_f_round_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic         bypass,
  output logic [127:0] state_out
);

  // Ascending packed index puts byte 0 in the most significant bits.
  logic [0:AES_BYTES-1][7:0] in_b;
  logic [0:AES_BYTES-1][7:0] mix_b;

  assign in_b = state_in;

  // Circulant matrix rows: {0e 0b 0d 09} rotated right by the row number.
  for (genvar c = 0; c < AES_NB; c++) begin : g_col
    assign mix_b[4*c+0] = gmul(in_b[4*c+0], 8'h0e) ^ gmul(in_b[4*c+1], 8'h0b) ^
                          gmul(in_b[4*c+2], 8'h0d) ^ gmul(in_b[4*c+3], 8'h09);
    assign mix_b[4*c+1] = gmul(in_b[4*c+0], 8'h09) ^ gmul(in_b[4*c+1], 8'h0e) ^
                          gmul(in_b[4*c+2], 8'h0b) ^ gmul(in_b[4*c+3], 8'h0d);
    assign mix_b[4*c+2] = gmul(in_b[4*c+0], 8'h0d) ^ gmul(in_b[4*c+1], 8'h09) ^
                          gmul(in_b[4*c+2], 8'h0e) ^ gmul(in_b[4*c+3], 8'h0b);
    assign mix_b[4*c+3] = gmul(in_b[4*c+0], 8'h0b) ^ gmul(in_b[4*c+1], 8'h0d) ^
                          gmul(in_b[4*c+2], 8'h09) ^ gmul(in_b[4*c+3], 8'h0e);
  end

  assign state_out = bypass ? state_in : mix_b;

endmodule

// File: rtl/inv_f_round.sv
// -----------------------------------------------------------------------------
// inv_f_round
// One AES-128 decryption round: AddRoundKey -> InvMixColumns -> InvShiftRows
// -> InvSubBytes. The inverse S-box is streamed in byte-serially and kept in a
// local 256x8 table; InvSubBytes does one table lookup per cycle.
//   clk, reset_n    : clock, asynchronous active-low reset
//   inv_sbox_in     : table byte, streamed from address 0 upward
//   inv_sbox_valid  : qualifies inv_sbox_in (honoured only in IDLE)
//   tvalid          : start request, taken when in_ready = 1
//   skip_mc         : 1 = bypass InvMixColumns, captured with tvalid
//   state_in        : input state, byte0 = [127:120], column-major
//   round_key       : round key, captured with tvalid
//   in_ready        : table loaded and FSM idle
//   table_ready     : all 256 table bytes have been loaded since reset
//   state_out       : round result, held until the next completion
//   valid           : one-cycle pulse when state_out updates
// Fixed latency: valid rises 18 cycles after the accepting clock edge.
// -----------------------------------------------------------------------------
module inv_f_round
  import inv_f_round_pkg::*;
#(
  parameter int SBOX_WIDTH = 8,
  parameter int SBOX_DEPTH = 256,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [SBOX_WIDTH-1:0] inv_sbox_in,
  input  logic                  inv_sbox_valid,
  input  logic                  tvalid,
  input  logic                  skip_mc,
  input  logic [DATA_WIDTH-1:0] state_in,
  input  logic [DATA_WIDTH-1:0] round_key,
  output logic                  in_ready,
  output logic                  table_ready,
  output logic [DATA_WIDTH-1:0] state_out,
  output logic                  valid
);

  localparam int ADDR_W = $clog2(SBOX_DEPTH);

  fsm_state_t state_q;
  fsm_state_t state_d;

  logic [SBOX_WIDTH-1:0]         sbox_mem [SBOX_DEPTH];
  logic [ADDR_W-1:0]             load_addr;
  logic                          load_en;
  logic                          accept;

  logic [DATA_WIDTH-1:0]         ark_q;     // state_in ^ round_key
  logic                          skip_q;
  logic [0:AES_BYTES-1][7:0]     work_q;    // byte 0 in the MSBs
  logic [3:0]                    idx_q;

  logic [DATA_WIDTH-1:0]         mixed;
  logic [0:AES_BYTES-1][7:0]     mixed_b;
  logic [0:AES_BYTES-1][7:0]     shifted_b;
  logic [7:0]                    sub_byte;

  assign in_ready = table_ready && (state_q == IDLE);
  assign accept   = tvalid && in_ready;
  assign load_en  = inv_sbox_valid && (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // InvMixColumns on the key-added state, then InvShiftRows as pure wiring:
  // row r rotates right by r, so out[r][c] takes in[r][(c - r) mod 4].
  // ---------------------------------------------------------------------------
  inv_mixcolumns u_inv_mixcolumns (
    .state_in  (ark_q),
    .bypass    (skip_q),
    .state_out (mixed)
  );

  assign mixed_b = mixed;

  for (genvar c = 0; c < AES_NB; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign shifted_b[4*c+r] = mixed_b[4*((c + 4 - r) % 4) + r];
    end
  end

  assign sub_byte = sbox_mem[work_q[idx_q]];

  // ---------------------------------------------------------------------------
  // Inverse S-box table.
  // NOTE: the table has no reset on purpose; it is plain RAM that must be
  // reloaded after reset anyway, and table_ready gates its use.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (load_en) sbox_mem[load_addr] <= inv_sbox_in;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // NOTE: every signal written here gets a default first so no latch can form.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MIX;
      MIX:     state_d = SUB;
      SUB:     if (idx_q == 4'd15) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register, load counter and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      load_addr   <= '0;
      table_ready <= 1'b0;
      ark_q       <= '0;
      skip_q      <= 1'b0;
      work_q      <= '0;
      idx_q       <= '0;
      state_out   <= '0;
      valid       <= 1'b0;
    end else begin
      state_q <= state_d;
      valid   <= (state_q == OUT);

      if (load_en) begin
        load_addr <= load_addr + 1'b1;
        // Set on the first wrap and never cleared; reloads keep it high.
        if (load_addr == '1) table_ready <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            ark_q  <= state_in ^ round_key;
            skip_q <= skip_mc;
          end
        end
        MIX: begin
          work_q <= shifted_b;
          idx_q  <= '0;
        end
        SUB: begin
          work_q[idx_q] <= sub_byte;
          idx_q         <= idx_q + 1'b1;
        end
        OUT: begin
          state_out <= work_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_f_round.sv
// -----------------------------------------------------------------------------
// tb_inv_f_round
// Self-checking bench for inv_f_round. The reference inverse S-box is derived
// from GF(2^8) inversion plus the AES affine map, and the round model works on
// a 4x4 byte matrix with carry-less multiplication reduced modulo 0x11B.
// -----------------------------------------------------------------------------
module tb_inv_f_round;

  logic         clk;
  logic         reset_n;
  logic [7:0]   inv_sbox_in;
  logic         inv_sbox_valid;
  logic         tvalid;
  logic         skip_mc;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         in_ready;
  logic         table_ready;
  logic [127:0] state_out;
  logic         valid;

  int tests_run;
  int tests_failed;

  logic [7:0] inv_tbl [256];

  inv_f_round dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .inv_sbox_in    (inv_sbox_in),
    .inv_sbox_valid (inv_sbox_valid),
    .tvalid         (tvalid),
    .skip_mc        (skip_mc),
    .state_in       (state_in),
    .round_key      (round_key),
    .in_ready       (in_ready),
    .table_ready    (table_ready),
    .state_out      (state_out),
    .valid          (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ ({7'b0, a} << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_inv_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      inv_tbl[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input bit skip);
    logic [7:0]   m [4][4];   // [row][col]
    logic [7:0]   t [4][4];
    logic [7:0]   coef [4];
    logic [127:0] x, res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    x = s ^ k;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = x[127 - 8*(4*c + r) -: 8];
    if (!skip) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          t[r][c] = 8'h00;
          for (int j = 0; j < 4; j++)
            t[r][c] = t[r][c] ^ gf_mul(coef[(j - r + 4) % 4], m[j][c]);
        end
      m = t;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = m[r][(c - r + 4) % 4];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = inv_tbl[t[r][c]];
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stream_table(output bit ready_gap);
    ready_gap = 1'b0;
    for (int i = 0; i < 256; i++) begin
      inv_sbox_valid = 1'b1;
      inv_sbox_in    = inv_tbl[i];
      tick();
      if (!table_ready && i != 255) ready_gap = 1'b1;
    end
    inv_sbox_valid = 1'b0;
  endtask

  // Launches one round and waits (bounded) for the valid pulse.
  task automatic do_round(input logic [127:0] s, input logic [127:0] k, input bit skip,
                          output logic [127:0] res, output int lat,
                          output bit ready_before, output bit busy_ok,
                          output bit valid_after);
    int cnt;
    ready_before = in_ready;
    state_in  = s;
    round_key = k;
    skip_mc   = skip;
    tvalid    = 1'b1;
    tick();
    tvalid  = 1'b0;
    cnt     = 1;
    busy_ok = 1'b1;
    while (!valid && cnt < 40) begin
      if (in_ready) busy_ok = 1'b0;
      tick();
      cnt++;
    end
    lat = cnt - 1;
    res = state_out;
    tick();
    valid_after = valid;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick();
    tests_run++;
    if ({valid, table_ready, in_ready} !== 3'b000) begin
      $display("FAIL reset_flags: valid/table_ready/in_ready=%b required 000",
               {valid, table_ready, in_ready});
      tests_failed++;
    end
    tests_run++;
    if (state_out !== 128'h0) begin
      $display("FAIL reset_state_out: got %h required 0", state_out);
      tests_failed++;
    end
  endtask

  task automatic test_load();
    bit  gap;
    logic before_last;
    for (int i = 0; i < 255; i++) begin
      inv_sbox_valid = 1'b1;
      inv_sbox_in    = inv_tbl[i];
      tick();
    end
    before_last    = table_ready;
    inv_sbox_valid = 1'b1;
    inv_sbox_in    = inv_tbl[255];
    tick();
    inv_sbox_valid = 1'b0;
    tests_run++;
    if (before_last !== 1'b0) begin
      $display("FAIL load_early_ready: table_ready=%b before byte 255, required 0", before_last);
      tests_failed++;
    end
    tests_run++;
    if ({table_ready, in_ready} !== 2'b11) begin
      $display("FAIL load_ready: table_ready/in_ready=%b required 11", {table_ready, in_ready});
      tests_failed++;
    end
    gap = 1'b0;
  endtask

  task automatic check_round(input string name, input logic [127:0] s, input logic [127:0] k,
                             input bit skip, input logic [127:0] exp);
    logic [127:0] res;
    int lat;
    bit rb, bo, va;
    do_round(s, k, skip, res, lat, rb, bo, va);
    tests_run++;
    if (rb !== 1'b1 || bo !== 1'b1) begin
      $display("FAIL %s_in_ready: before=%b during_busy_low=%b required 1 1", name, rb, bo);
      tests_failed++;
    end
    tests_run++;
    if (lat != 18) begin
      $display("FAIL %s_latency: got %0d required 18", name, lat);
      tests_failed++;
    end
    tests_run++;
    if (res !== exp) begin
      $display("FAIL %s_state_out: got %h required %h", name, res, exp);
      tests_failed++;
    end
    tests_run++;
    if (va !== 1'b0) begin
      $display("FAIL %s_valid_width: valid=%b one cycle after pulse, required 0", name, va);
      tests_failed++;
    end
  endtask

  task automatic test_zero_state();
    check_round("zero_state", 128'h0, 128'h0, 1'b1, {16{8'h52}});
  endtask

  task automatic test_key_path();
    check_round("key_path", 128'h0, {16{8'h01}}, 1'b0, {16{8'h09}});
  endtask

  task automatic test_invmc_vector();
    check_round("invmc_vec", {4{32'h8e4da1bc}}, 128'h0, 1'b0, {4{32'h9f825068}});
  endtask

  task automatic test_random();
    logic [127:0] s, k;
    bit skip;
    for (int n = 0; n < 10; n++) begin
      s    = {$urandom, $urandom, $urandom, $urandom};
      k    = {$urandom, $urandom, $urandom, $urandom};
      skip = 1'($urandom_range(0, 1));
      check_round($sformatf("random%0d", n), s, k, skip, model_round(s, k, skip));
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] s, k, exp;
    int valids;
    s   = {$urandom, $urandom, $urandom, $urandom};
    k   = {$urandom, $urandom, $urandom, $urandom};
    exp = model_round(s, k, 1'b0);
    state_in  = s;
    round_key = k;
    skip_mc   = 1'b0;
    tvalid    = 1'b1;
    valids    = 0;
    for (int c = 0; c < 57; c++) begin
      tests_run++;
      if (in_ready !== (c % 19 == 0)) begin
        $display("FAIL b2b_in_ready: cycle %0d got %b required %b", c, in_ready, (c % 19 == 0));
        tests_failed++;
      end
      tick();
      if (c == 56) tvalid = 1'b0;
      tests_run++;
      if (valid !== (c % 19 == 18)) begin
        $display("FAIL b2b_valid: cycle %0d got %b required %b", c, valid, (c % 19 == 18));
        tests_failed++;
      end
      if (valid) begin
        valids++;
        tests_run++;
        if (state_out !== exp) begin
          $display("FAIL b2b_state_out: got %h required %h", state_out, exp);
          tests_failed++;
        end
      end
    end
    tests_run++;
    if (valids != 3) begin
      $display("FAIL b2b_count: got %0d valid pulses required 3", valids);
      tests_failed++;
    end
  endtask

  // Table writes offered while a round runs must be ignored and must not move
  // the load counter: a full reload afterwards has to land at address 0.
  task automatic test_load_while_busy();
    bit gap;
    state_in  = 128'h0;
    round_key = 128'h0;
    skip_mc   = 1'b1;
    tvalid    = 1'b1;
    tick();
    tvalid         = 1'b0;
    inv_sbox_valid = 1'b1;
    inv_sbox_in    = 8'h00;
    repeat (17) tick();
    inv_sbox_valid = 1'b0;
    tick();
    tests_run++;
    if (valid !== 1'b1 || state_out !== {16{8'h52}}) begin
      $display("FAIL busy_write_ignored: valid=%b state_out=%h required 1 %h",
               valid, state_out, {16{8'h52}});
      tests_failed++;
    end
    tick();
    stream_table(gap);
    tests_run++;
    if (gap) begin
      $display("FAIL reload_ready_gap: table_ready dropped during reload, required steady 1");
      tests_failed++;
    end
    check_round("after_reload", 128'h0, 128'h0, 1'b1, {16{8'h52}});
  endtask

  task automatic test_reset_mid_sub();
    bit seen;
    bit gap;
    state_in  = 128'h0;
    round_key = 128'h0;
    skip_mc   = 1'b1;
    tvalid    = 1'b1;
    tick();
    tvalid = 1'b0;
    repeat (8) tick();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({valid, table_ready, in_ready} !== 3'b000 || state_out !== 128'h0) begin
      $display("FAIL midreset_outputs: valid/table_ready/in_ready=%b state_out=%h required 000 0",
               {valid, table_ready, in_ready}, state_out);
      tests_failed++;
    end
    repeat (3) tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (valid) seen = 1'b1;
    end
    tests_run++;
    if (seen || table_ready !== 1'b0) begin
      $display("FAIL midreset_no_valid: valid_seen=%b table_ready=%b required 0 0",
               seen, table_ready);
      tests_failed++;
    end
    stream_table(gap);
    check_round("midreset_repeat", 128'h0, 128'h0, 1'b1, {16{8'h52}});
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset_n        = 1'b0;
    inv_sbox_in    = 8'h00;
    inv_sbox_valid = 1'b0;
    tvalid         = 1'b0;
    skip_mc        = 1'b0;
    state_in       = '0;
    round_key      = '0;
    build_inv_sbox();
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    tick();
    test_load();
    test_zero_state();
    test_key_path();
    test_invmc_vector();
    test_random();
    test_back_to_back();
    tick();
    test_load_while_busy();
    test_reset_mid_sub();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
